// File: rtl/io_mux_pkg.sv
// rtl/io_mux_pkg.sv - shared mode/state encodings for the pad function mux
package io_mux_pkg;

    typedef enum logic [2:0] {
        MODE_FUN    = 3'd0,
        MODE_DBG    = 3'd1,
        MODE_TEST_A = 3'd2,
        MODE_TEST_B = 3'd3,
        MODE_NONE   = 3'd4
    } mode_e;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_QUIESCE = 1'b1
    } state_e;

    // Test and idle targets take the pad immediately; only FUN/DBG need quiescing.
    function automatic logic is_bypass(input mode_e m);
        return (m == MODE_TEST_A) || (m == MODE_TEST_B) || (m == MODE_NONE);
    endfunction

endpackage

// File: rtl/io_sync_cell.sv
// rtl/io_sync_cell.sv - pad input synchroniser, SYNC flops or a wire when SYNC=0
module io_sync_cell #(
    parameter int SYNC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    generate
        if (SYNC == 0) begin : g_pass
            logic unused_clk;
            assign unused_clk = clk ^ rst_n;
            assign q = d;
        end else begin : g_ff
            logic [SYNC-1:0] sr;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sr <= '0;
                end else begin
                    sr <= {sr[SYNC-2:0], d};
                end
            end
            assign q = sr[SYNC-1];
        end
    endgenerate

endmodule

// File: rtl/io_muxn_cell.sv
// rtl/io_muxn_cell.sv - N-function pad mux with debug/test override and switch guard
module io_muxn_cell
    import io_mux_pkg::*;
#(
    parameter  int NFUN  = 4,
    parameter  int GUARD = 2,
    parameter  int SYNC  = 2,
    localparam int SELW  = (NFUN > 1) ? $clog2(NFUN) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      testmode,
    input  logic            dbg_en,
    input  logic [SELW-1:0] fun_sel,
    output logic [NFUN-1:0] fun_i,
    input  logic [NFUN-1:0] fun_ie,
    input  logic [NFUN-1:0] fun_o,
    input  logic [NFUN-1:0] fun_oe,
    input  logic [NFUN-1:0] default_fun_i,
    output logic            dbg_i,
    input  logic            dbg_ie,
    input  logic            dbg_o,
    input  logic            dbg_oe,
    input  logic            default_dbg_i,
    output logic [1:0]      test_i,
    input  logic [1:0]      test_ie,
    input  logic [1:0]      test_o,
    input  logic [1:0]      test_oe,
    input  logic [1:0]      default_test_i,
    input  logic            cell_i,
    output logic            cell_ie,
    output logic            cell_o,
    output logic            cell_oe,
    output logic            busy,
    output logic [2:0]      act_mode,
    output logic [SELW-1:0] act_sel
);

    localparam logic [SELW:0] NFUN_L  = NFUN[SELW:0];
    localparam logic [3:0]    GUARD_L = GUARD[3:0];

    state_e          state, state_nxt;
    mode_e           act_m, act_m_nxt, tgt_m, pend_m, pend_m_nxt;
    logic [SELW-1:0] act_s, act_s_nxt, tgt_s, pend_s, pend_s_nxt;
    logic            pend_vld, pend_vld_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic            cell_sync;
    logic            tgt_diff_act, tgt_diff_pend;

    io_sync_cell #(.SYNC(SYNC)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cell_i),
        .q     (cell_sync)
    );

    always_comb begin
        tgt_m = MODE_NONE;
        tgt_s = '0;
        case (testmode)
            2'b01:   tgt_m = MODE_TEST_A;
            2'b10:   tgt_m = MODE_TEST_B;
            2'b11:   tgt_m = MODE_NONE;
            default: begin
                if (dbg_en) begin
                    tgt_m = MODE_DBG;
                end else if ({1'b0, fun_sel} < NFUN_L) begin
                    tgt_m = MODE_FUN;
                    tgt_s = fun_sel;
                end
            end
        endcase
    end

    assign tgt_diff_act  = (tgt_m != act_m)  || (tgt_s != act_s);
    assign tgt_diff_pend = (tgt_m != pend_m) || (tgt_s != pend_s);

    // pend_* remembers the previous quiesce-cycle target so a change restarts the guard.
    always_comb begin
        state_nxt    = state;
        act_m_nxt    = act_m;
        act_s_nxt    = act_s;
        pend_m_nxt   = pend_m;
        pend_s_nxt   = pend_s;
        pend_vld_nxt = pend_vld;
        cnt_nxt      = cnt;
        if (state == ST_RUN) begin
            if (tgt_diff_act) begin
                if (is_bypass(tgt_m)) begin
                    act_m_nxt = tgt_m;
                    act_s_nxt = tgt_s;
                end else begin
                    state_nxt    = ST_QUIESCE;
                    cnt_nxt      = GUARD_L;
                    pend_m_nxt   = tgt_m;
                    pend_s_nxt   = tgt_s;
                    pend_vld_nxt = 1'b1;
                end
            end
        end else begin
            pend_m_nxt   = tgt_m;
            pend_s_nxt   = tgt_s;
            pend_vld_nxt = 1'b1;
            if (is_bypass(tgt_m) || (!(pend_vld && tgt_diff_pend) && cnt == 4'd1)) begin
                state_nxt    = ST_RUN;
                act_m_nxt    = tgt_m;
                act_s_nxt    = tgt_s;
                pend_vld_nxt = 1'b0;
            end else if (pend_vld && tgt_diff_pend) begin
                cnt_nxt = GUARD_L;
            end else begin
                cnt_nxt = cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_QUIESCE;
            cnt      <= GUARD_L;
            act_m    <= MODE_NONE;
            act_s    <= '0;
            pend_m   <= MODE_NONE;
            pend_s   <= '0;
            pend_vld <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            act_m    <= act_m_nxt;
            act_s    <= act_s_nxt;
            pend_m   <= pend_m_nxt;
            pend_s   <= pend_s_nxt;
            pend_vld <= pend_vld_nxt;
        end
    end

    always_comb begin
        cell_o  = 1'b0;
        cell_oe = 1'b0;
        cell_ie = 1'b0;
        fun_i   = default_fun_i;
        dbg_i   = default_dbg_i;
        test_i  = default_test_i;
        if (state == ST_RUN) begin
            case (act_m)
                MODE_FUN: begin
                    cell_o  = fun_o[act_s];
                    cell_oe = fun_oe[act_s];
                    cell_ie = fun_ie[act_s];
                    if (fun_ie[act_s]) fun_i[act_s] = cell_sync;
                end
                MODE_DBG: begin
                    cell_o  = dbg_o;
                    cell_oe = dbg_oe;
                    cell_ie = dbg_ie;
                    if (dbg_ie) dbg_i = cell_sync;
                end
                MODE_TEST_A: begin
                    cell_o  = test_o[0];
                    cell_oe = test_oe[0];
                    cell_ie = test_ie[0];
                    if (test_ie[0]) test_i[0] = cell_sync;
                end
                MODE_TEST_B: begin
                    cell_o  = test_o[1];
                    cell_oe = test_oe[1];
                    cell_ie = test_ie[1];
                    if (test_ie[1]) test_i[1] = cell_sync;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state == ST_QUIESCE);
    assign act_mode = act_m;
    assign act_sel  = act_s;

endmodule

// File: tb/tb_io_muxn_cell.sv
// tb/tb_io_muxn_cell.sv - self-checking bench for io_muxn_cell
module tb_io_muxn_cell;

    localparam int GUARD = 2;

    logic       clk, rst_n;
    logic [1:0] testmode;
    logic       dbg_en;
    logic [1:0] fun_sel;
    logic [3:0] fun_ie, fun_o, fun_oe, default_fun_i;
    logic       dbg_ie, dbg_o, dbg_oe, default_dbg_i;
    logic [1:0] test_ie, test_o, test_oe, default_test_i;
    logic       cell_i;

    logic [3:0] d_fun_i;   logic d_dbg_i;   logic [1:0] d_test_i;
    logic d_cell_ie, d_cell_o, d_cell_oe, d_busy;
    logic [2:0] d_act_mode; logic [1:0] d_act_sel;

    logic [3:0] s_fun_i;   logic s_dbg_i;   logic [1:0] s_test_i;
    logic s_cell_ie, s_cell_o, s_cell_oe, s_busy;
    logic [2:0] s_act_mode; logic [1:0] s_act_sel;

    logic [2:0] a_fun_i;   logic a_dbg_i;   logic [1:0] a_test_i;
    logic a_cell_ie, a_cell_o, a_cell_oe, a_busy;
    logic [2:0] a_act_mode; logic [1:0] a_act_sel;

    int n_tests = 0;
    int n_fail  = 0;

    io_muxn_cell #(.NFUN(4), .GUARD(GUARD), .SYNC(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .testmode(testmode), .dbg_en(dbg_en), .fun_sel(fun_sel),
        .fun_i(d_fun_i), .fun_ie(fun_ie), .fun_o(fun_o), .fun_oe(fun_oe), .default_fun_i(default_fun_i),
        .dbg_i(d_dbg_i), .dbg_ie(dbg_ie), .dbg_o(dbg_o), .dbg_oe(dbg_oe), .default_dbg_i(default_dbg_i),
        .test_i(d_test_i), .test_ie(test_ie), .test_o(test_o), .test_oe(test_oe), .default_test_i(default_test_i),
        .cell_i(cell_i), .cell_ie(d_cell_ie), .cell_o(d_cell_o), .cell_oe(d_cell_oe),
        .busy(d_busy), .act_mode(d_act_mode), .act_sel(d_act_sel)
    );

    io_muxn_cell #(.NFUN(4), .GUARD(1), .SYNC(0)) u_s0 (
        .clk(clk), .rst_n(rst_n), .testmode(testmode), .dbg_en(dbg_en), .fun_sel(fun_sel),
        .fun_i(s_fun_i), .fun_ie(fun_ie), .fun_o(fun_o), .fun_oe(fun_oe), .default_fun_i(default_fun_i),
        .dbg_i(s_dbg_i), .dbg_ie(dbg_ie), .dbg_o(dbg_o), .dbg_oe(dbg_oe), .default_dbg_i(default_dbg_i),
        .test_i(s_test_i), .test_ie(test_ie), .test_o(test_o), .test_oe(test_oe), .default_test_i(default_test_i),
        .cell_i(cell_i), .cell_ie(s_cell_ie), .cell_o(s_cell_o), .cell_oe(s_cell_oe),
        .busy(s_busy), .act_mode(s_act_mode), .act_sel(s_act_sel)
    );

    io_muxn_cell #(.NFUN(3), .GUARD(3), .SYNC(3)) u_alt (
        .clk(clk), .rst_n(rst_n), .testmode(testmode), .dbg_en(dbg_en), .fun_sel(fun_sel),
        .fun_i(a_fun_i), .fun_ie(fun_ie[2:0]), .fun_o(fun_o[2:0]), .fun_oe(fun_oe[2:0]),
        .default_fun_i(default_fun_i[2:0]),
        .dbg_i(a_dbg_i), .dbg_ie(dbg_ie), .dbg_o(dbg_o), .dbg_oe(dbg_oe), .default_dbg_i(default_dbg_i),
        .test_i(a_test_i), .test_ie(test_ie), .test_o(test_o), .test_oe(test_oe), .default_test_i(default_test_i),
        .cell_i(cell_i), .cell_ie(a_cell_ie), .cell_o(a_cell_o), .cell_oe(a_cell_oe),
        .busy(a_busy), .act_mode(a_act_mode), .act_sel(a_act_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode codes 0=FUN 1=DBG 2=TEST_A 3=TEST_B 4=NONE.
    bit m_busy;
    int m_mode, m_sel, m_stable, m_ref_mode, m_ref_sel;
    bit m_ref_vld;
    bit hist [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void target(output int m, output int s);
        s = 0;
        case (testmode)
            2'd1: m = 2;
            2'd2: m = 3;
            2'd3: m = 4;
            default: begin
                if (dbg_en) m = 1;
                else begin m = 0; s = int'(fun_sel); end
            end
        endcase
    endfunction

    task automatic model_reset();
        m_busy = 1; m_mode = 4; m_sel = 0; m_stable = 0; m_ref_vld = 0;
        m_ref_mode = 4; m_ref_sel = 0;
        for (int i = 0; i < 4; i++) hist[i] = 0;
    endtask

    // A switch to FUN/DBG completes once the target has held still for GUARD quiesce cycles.
    task automatic model_edge();
        int tm, ts;
        if (!rst_n) begin model_reset(); return; end
        target(tm, ts);
        if (!m_busy) begin
            if (tm != m_mode || ts != m_sel) begin
                if (tm >= 2) begin m_mode = tm; m_sel = ts; end
                else begin
                    m_busy = 1; m_stable = 0;
                    m_ref_mode = tm; m_ref_sel = ts; m_ref_vld = 1;
                end
            end
        end else if (tm >= 2) begin
            m_busy = 0; m_mode = tm; m_sel = ts;
        end else if (m_ref_vld && (tm != m_ref_mode || ts != m_ref_sel)) begin
            m_stable = 0; m_ref_mode = tm; m_ref_sel = ts;
        end else begin
            m_stable++; m_ref_mode = tm; m_ref_sel = ts; m_ref_vld = 1;
            if (m_stable == GUARD) begin m_busy = 0; m_mode = tm; m_sel = ts; end
        end
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = cell_i;
    endtask

    task automatic check_model(input string tag);
        logic sync, e_o, e_oe, e_ie, e_di;
        logic [3:0] e_fi;
        logic [1:0] e_ti;
        sync = hist[1];
        e_o = 0; e_oe = 0; e_ie = 0;
        e_fi = default_fun_i; e_di = default_dbg_i; e_ti = default_test_i;
        if (!m_busy) begin
            case (m_mode)
                0: begin e_o = fun_o[m_sel]; e_oe = fun_oe[m_sel]; e_ie = fun_ie[m_sel];
                          if (fun_ie[m_sel]) e_fi[m_sel] = sync; end
                1: begin e_o = dbg_o; e_oe = dbg_oe; e_ie = dbg_ie; if (dbg_ie) e_di = sync; end
                2: begin e_o = test_o[0]; e_oe = test_oe[0]; e_ie = test_ie[0];
                          if (test_ie[0]) e_ti[0] = sync; end
                3: begin e_o = test_o[1]; e_oe = test_oe[1]; e_ie = test_ie[1];
                          if (test_ie[1]) e_ti[1] = sync; end
                default: ;
            endcase
        end
        chk({tag, "_status"}, {d_busy, d_act_mode, d_act_sel},
            {m_busy, 3'(m_mode), 2'(m_sel)});
        chk({tag, "_pad"}, {d_cell_o, d_cell_oe, d_cell_ie}, {e_o, e_oe, e_ie});
        chk({tag, "_ins"}, {d_fun_i, d_dbg_i, d_test_i}, {e_fi, e_di, e_ti});
    endtask

    // Entered at a falling edge with inputs just driven; returns at the next falling edge.
    task automatic cycle(input string tag);
        #1 check_model(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic rand_data();
        {fun_ie, fun_o, fun_oe, default_fun_i} = 16'($urandom);
        {dbg_ie, dbg_o, dbg_oe, default_dbg_i} = 4'($urandom);
        {test_ie, test_o, test_oe, default_test_i} = 8'($urandom);
        cell_i = 1'($urandom);
    endtask

    typedef struct {
        logic [1:0] tm;
        logic       dbg;
        logic [1:0] sel;
        logic [2:0] exp_mode;
        logic [1:0] exp_sel;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{2'd0, 1'b0, 2'd0, 3'd0, 2'd0};
        vecs[1] = '{2'd0, 1'b0, 2'd3, 3'd0, 2'd3};
        vecs[2] = '{2'd0, 1'b1, 2'd2, 3'd1, 2'd0};
        vecs[3] = '{2'd1, 1'b1, 2'd1, 3'd2, 2'd0};
        vecs[4] = '{2'd2, 1'b0, 2'd1, 3'd3, 2'd0};
        vecs[5] = '{2'd3, 1'b0, 2'd2, 3'd4, 2'd0};
        vecs[6] = '{2'd0, 1'b0, 2'd1, 3'd0, 2'd1};
        vecs[7] = '{2'd0, 1'b1, 2'd0, 3'd1, 2'd0};

        rst_n = 0; testmode = 0; dbg_en = 0; fun_sel = 2'd1;
        rand_data();
        default_fun_i = 4'b1010;
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_busy", d_busy, 1);
        chk("rst_mode", d_act_mode, 4);
        chk("rst_sel", d_act_sel, 0);
        chk("rst_pad", {d_cell_o, d_cell_oe, d_cell_ie}, 0);
        chk("rst_fun_i", d_fun_i, 4'b1010);
        cycle("rst_hold");

        // Reset release into FUN1
        rst_n = 1; fun_sel = 2'd1; rand_data();
        #1 chk("rel_busy_c1", d_busy, 1);
        cycle("rel1");
        rand_data();
        #1 chk("rel_busy_c2", d_busy, 1);
        cycle("rel2");
        rand_data();
        #1 chk("rel_run", {d_busy, d_act_mode, d_act_sel}, {1'b0, 3'd0, 2'd1});
        chk("rel_cell_o", d_cell_o, fun_o[1]);
        cycle("rel3");

        // FUN1 -> FUN2 with the guard window
        fun_sel = 2'd2; rand_data();
        #1 chk("sw_old_oe", d_cell_oe, fun_oe[1]);
        cycle("sw0");
        for (int k = 0; k < 2; k++) begin
            rand_data();
            #1 chk("sw_guard_oe", d_cell_oe, 0);
            chk("sw_guard_fun_i", d_fun_i[2:1], default_fun_i[2:1]);
            cycle("swg");
        end
        rand_data();
        #1 chk("sw_new_oe", d_cell_oe, fun_oe[2]);
        cycle("sw3");

        // Guard restart: 2 -> 1 -> 3
        fun_sel = 2'd1; rand_data(); cycle("rs0");
        rand_data(); cycle("rs1");
        fun_sel = 2'd3; rand_data(); cycle("rs2");
        rand_data(); #1 chk("rs_busy1", d_busy, 1); cycle("rs3");
        rand_data(); #1 chk("rs_busy2", d_busy, 1); cycle("rs4");
        rand_data();
        #1 chk("rs_exit", {d_busy, d_act_mode, d_act_sel}, {1'b0, 3'd0, 2'd3});
        cycle("rs5");

        // TEST_A bypasses an in-progress guard
        fun_sel = 2'd0; rand_data(); cell_i = 0; test_ie = 2'b01; cycle("ta0");
        testmode = 2'd1;
        #1 chk("ta_busy_before", d_busy, 1);
        cycle("ta1");
        cell_i = 1;
        #1 chk("ta_mode", {d_busy, d_act_mode}, {1'b0, 3'd2});
        chk("ta_sync0", d_test_i[0], 0);
        cycle("ta2");
        #1 chk("ta_sync1", d_test_i[0], 0);
        cycle("ta3");
        #1 chk("ta_sync2", d_test_i[0], 1);
        cycle("ta4");

        // NONE via testmode=11 and via out-of-range fun_sel on NFUN=3
        testmode = 2'd3; fun_ie = 4'hF; fun_oe = 4'hF; test_ie = 2'b11; dbg_ie = 1;
        default_fun_i = 4'b0110; default_dbg_i = 0; default_test_i = 2'b10;
        cycle("nn0");
        #1 chk("none_pad", {d_cell_oe, d_cell_ie}, 0);
        chk("none_ins", {d_fun_i, d_dbg_i, d_test_i}, {4'b0110, 1'b0, 2'b10});
        cycle("nn1");
        testmode = 2'd0; fun_sel = 2'd3;
        cycle("nn2");
        #1 chk("alt_none_mode", {a_busy, a_act_mode}, {1'b0, 3'd4});
        chk("alt_none_pad", {a_cell_oe, a_cell_ie}, 0);
        chk("alt_none_ins", {a_fun_i, a_dbg_i, a_test_i}, {3'b110, 1'b0, 2'b10});
        cycle("nn3");

        // cell_i pulse through SYNC=0 and SYNC=3 instances
        fun_sel = 2'd0; default_fun_i = 0; cell_i = 0;
        for (int k = 0; k < 6; k++) cycle("pl_settle");
        for (int k = 0; k < 6; k++) begin
            cell_i = (k == 0);
            #1 chk("s0_pulse", s_fun_i[0], (k == 0));
            chk("s3_pulse", a_fun_i[0], (k == 3));
            cycle("pl");
        end

        // Asynchronous reset mid-RUN and mid-guard
        #2 rst_n = 0; model_reset();
        #1 chk("arst_run", {d_busy, d_act_mode, d_act_sel, d_cell_oe}, {1'b1, 3'd4, 2'd0, 1'b0});
        @(negedge clk);
        rst_n = 1; fun_sel = 2'd0;
        for (int k = 0; k < 3; k++) cycle("ar_rel");
        fun_sel = 2'd1; rand_data(); cycle("ar_sw");
        #2 rst_n = 0; model_reset();
        #1 chk("arst_guard", {d_busy, d_act_mode, d_act_sel, d_cell_oe}, {1'b1, 3'd4, 2'd0, 1'b0});
        chk("arst_fun_i", d_fun_i, default_fun_i);
        @(negedge clk);
        rst_n = 1;

        // Table of steady-state targets
        for (int v = 0; v < 8; v++) begin
            testmode = vecs[v].tm; dbg_en = vecs[v].dbg; fun_sel = vecs[v].sel;
            for (int k = 0; k < 4; k++) begin rand_data(); cycle("tbl"); end
            #1 chk($sformatf("tbl%0d_mode", v), {d_act_mode, d_act_sel},
                   {vecs[v].exp_mode, vecs[v].exp_sel});
            cycle("tbl_end");
        end

        // Randomized mode traffic against the model
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                testmode = ($urandom_range(0, 9) < 7) ? 2'd0 : 2'($urandom);
                dbg_en   = ($urandom_range(0, 3) == 0);
                fun_sel  = 2'($urandom);
            end
            rand_data();
            cycle("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/io_muxn_cell.md
IO_MUXN_CELL -- requirements
Module: io_muxn_cell

Interface
REQ-001 The block SHALL have parameter NFUN, default 4, number of function sources, legal 2..16.
REQ-002 The block SHALL have parameter GUARD, default 2, quiesce cycles on a function/debug switch, legal 1..15.
REQ-003 The block SHALL have parameter SYNC, default 2, cell_i synchroniser stages, legal 0, 2 or 3.
REQ-004 The block SHALL have derived localparam SELW = max(1, clog2(NFUN)).
REQ-005 The block SHALL use one clock and an asynchronous active-low reset: clk  in  1  block clock; rst_n  in  1  async reset, active low.
REQ-006 Mode ports SHALL be: testmode  in  2  test select; dbg_en  in  1  debug select; fun_sel  in  SELW  function index.
REQ-007 Function ports SHALL be: fun_i  out  NFUN; fun_ie, fun_o, fun_oe, default_fun_i  in  NFUN; bit k belongs to function k.
REQ-008 Debug ports SHALL be: dbg_i  out  1; dbg_ie, dbg_o, dbg_oe, default_dbg_i  in  1.
REQ-009 Test ports SHALL be: test_i  out  2; test_ie, test_o, test_oe, default_test_i  in  2; bit0 = test A, bit1 = test B.
REQ-010 Pad ports SHALL be: cell_i  in  1; cell_ie, cell_o, cell_oe  out  1.
REQ-011 Status ports SHALL be: busy  out  1  switch in progress; act_mode  out  3  active mode code; act_sel  out  SELW  active function index.

Function
REQ-012 Target mode SHALL be: testmode 01 -> TEST_A; 10 -> TEST_B; 11 -> NONE; 00 with dbg_en -> DBG; otherwise FUN with index fun_sel.
REQ-013 A fun_sel value >= NFUN SHALL map to target NONE.
REQ-014 The FSM SHALL have states RUN and QUIESCE; the active mode/index registers (act_mode, act_sel) SHALL change only on entry to RUN.
REQ-015 In RUN, a target differing from active at cycle t SHALL cause QUIESCE during cycles t+1..t+GUARD and RUN with the new active value from t+GUARD+1.
REQ-016 A target change during QUIESCE SHALL restart the guard count from GUARD; the value latched on exit SHALL be the target at the final QUIESCE cycle.
REQ-017 A target of TEST_A, TEST_B or NONE SHALL bypass the guard: active updates at t+1, state RUN, busy stays 0.
REQ-018 In QUIESCE, or with active NONE: cell_o=0, cell_oe=0, cell_ie=0, every *_i output = its default_* input.
REQ-019 In RUN, cell_o, cell_oe and cell_ie SHALL combinationally follow the active source's o/oe/ie inputs (zero latency).
REQ-020 The active source's *_i SHALL equal the synchronised cell_i when its ie=1, else its default; all other *_i SHALL equal their defaults.
REQ-021 The synchronised cell_i SHALL be SYNC flops of cell_i; SYNC=0 SHALL mean a combinational pass-through.
REQ-022 busy SHALL equal 1 exactly when the state is QUIESCE.

Reset
REQ-023 While rst_n=0: state QUIESCE, guard counter=GUARD, act_mode=NONE, act_sel=0, synchroniser flops=0, and all outputs per REQ-018.
REQ-024 After rst_n deasserts, the FSM SHALL complete one full guard period and then latch the target.
REQ-025 Reset assertion mid-switch or mid-RUN SHALL force the REQ-023 values asynchronously, without waiting for clk.

Structure
REQ-026 Shared package io_mux_pkg SHALL hold the mode code enum (FUN=0, DBG=1, TEST_A=2, TEST_B=3, NONE=4) and the FSM state enum.
REQ-027 The synchroniser SHALL be the sub-module io_sync_cell, parametrised by SYNC, reset to 0.
REQ-028 The FSM, guard counter and output muxing SHALL reside in io_muxn_cell.

Verification
REQ-029 Reset release with fun_sel=1, testmode=00, dbg_en=0 -> busy=1 for cycles 1..2, then act_mode=FUN and act_sel=1; cell_o tracks fun_o[1].
REQ-030 In RUN FUN1, switch to fun_sel=2 -> cell_oe=0 for exactly 2 cycles, then cell_oe=fun_oe[2]; fun_i[1] and fun_i[2] = defaults during the guard.
REQ-031 A fun_sel change 1->2->3 with the second change inside the guard -> guard restarts; the block exits to FUN3 after 2 cycles from the last change.
REQ-032 testmode=01 asserted while busy -> act_mode=TEST_A next cycle; busy=0; test_i[0]=cell_i (SYNC delayed) when test_ie[0]=1.
REQ-033 testmode=11, or NFUN=3 with fun_sel=3 -> cell_oe=0 and cell_ie=0, all *_i outputs = defaults.
REQ-034 Vary SYNC=0/3 with a cell_i pulse -> fun_i follows with 0 or 3 cycle delay; rst_n pulse mid-guard -> immediate REQ-023 values.
